// File: rtl/bullet_pkg.sv
// bullet_pkg: direction encoding, direction-to-delta decode, plot states and default screen bounds
package bullet_pkg;
    typedef enum logic [2:0] {DIR_N, DIR_NE, DIR_E, DIR_SE, DIR_S, DIR_SW, DIR_W, DIR_NW} dir_t;
    typedef enum logic [1:0] {IDLE, ERASE, DRAW, NEXT} plot_state_t;
    typedef struct packed {
        logic [1:0] dx;
        logic [1:0] dy;
    } delta_t;
    localparam int X_MAX_DEF = 159;
    localparam int Y_MAX_DEF = 119;
    function automatic delta_t dir_delta(input dir_t d);
        delta_t r;
        r.dx = (d == DIR_NE || d == DIR_E || d == DIR_SE) ? 2'b01 :
               (d == DIR_SW || d == DIR_W || d == DIR_NW) ? 2'b11 : 2'b00;
        r.dy = (d == DIR_SE || d == DIR_S || d == DIR_SW) ? 2'b01 :
               (d == DIR_NW || d == DIR_N || d == DIR_NE) ? 2'b11 : 2'b00;
        return r;
    endfunction
endpackage

// File: rtl/bullet_pool_if.sv
// bullet_pool_if: pixel request/acknowledge bus from the bullet pool to the VGA drawer
interface bullet_pool_if #(
    parameter int X_W = 8,
    parameter int Y_W = 7
);
    logic req;
    logic ack;
    logic erase;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    modport master(output req, x, y, erase, input ack);
    modport slave(input req, x, y, erase, output ack);
endinterface

// File: rtl/bullet_slot.sv
// bullet_slot: one bullet's position registers, move adder and screen-edge check
module bullet_slot
    import bullet_pkg::*;
#(
    parameter int X_MAX = X_MAX_DEF,
    parameter int Y_MAX = Y_MAX_DEF,
    parameter int X_W = 8,
    parameter int Y_W = 7
) (
    input  logic clk,
    input  logic resetn,
    input  logic tick,
    input  logic load,
    input  logic collide,
    input  logic [X_W-1:0] start_x,
    input  logic [Y_W-1:0] start_y,
    input  dir_t dir,
    output logic active,
    output logic [X_W-1:0] x,
    output logic [X_W-1:0] ox,
    output logic [Y_W-1:0] y,
    output logic [Y_W-1:0] oy,
    output logic er,
    output logic dr
);
    dir_t d;
    delta_t dl;
    logic [X_W-1:0] nx;
    logic [Y_W-1:0] ny;
    logic hit;
    logic mv;
    assign dl = dir_delta(d);
    assign nx = x + {{(X_W-2){dl.dx[1]}}, dl.dx};
    assign ny = y + {{(Y_W-2){dl.dy[1]}}, dl.dy};
    assign hit = nx == '0 || nx == X_W'(X_MAX) || ny == '0 || ny == Y_W'(Y_MAX);
    assign mv = tick && active;
    // er/dr record what the current plot pass owes this slot; collide only cancels the draw
    always_ff @(posedge clk) begin
        if (!resetn) begin
            active <= 1'b0;
            x <= '0;
            y <= '0;
            ox <= '0;
            oy <= '0;
            d <= DIR_N;
            er <= 1'b0;
            dr <= 1'b0;
        end else begin
            active <= load || (active && !collide && !(mv && hit));
            er <= tick ? active : er;
            dr <= tick ? mv && !hit && !collide : dr && !collide;
            if (mv) begin
                ox <= x;
                oy <= y;
                x <= nx;
                y <= ny;
            end
            if (load) begin
                x <= start_x;
                y <= start_y;
                d <= dir;
            end
        end
    end
endmodule

// File: rtl/bullet_pool.sv
// bullet_pool: bullet slot allocator, movement tick counter and erase/draw plot sequencer
module bullet_pool
    import bullet_pkg::*;
#(
    parameter int NUM_BULLETS = 4,
    parameter int X_MAX = X_MAX_DEF,
    parameter int Y_MAX = Y_MAX_DEF,
    parameter int X_W = 8,
    parameter int Y_W = 7,
    parameter int STEP_DIV = 10
) (
    input  logic clk,
    input  logic resetn,
    input  logic fire,
    input  logic [X_W-1:0] start_x,
    input  logic [Y_W-1:0] start_y,
    input  logic [2:0] dir,
    input  logic [NUM_BULLETS-1:0] collide,
    output logic [NUM_BULLETS-1:0] active,
    output logic fire_drop,
    bullet_pool_if.master plot
);
    localparam int CW = $clog2(STEP_DIV);
    localparam int IW = NUM_BULLETS > 1 ? $clog2(NUM_BULLETS) : 1;
    plot_state_t state, state_n;
    logic [IW-1:0] idx, idx_n, nidx;
    logic [CW-1:0] cnt;
    logic [X_W-1:0] px_n;
    logic [Y_W-1:0] py_n;
    logic pe_n;
    logic tick;
    logic last;
    logic [NUM_BULLETS-1:0] load, er, dr;
    logic [X_W-1:0] xs [NUM_BULLETS];
    logic [X_W-1:0] oxs [NUM_BULLETS];
    logic [Y_W-1:0] ys [NUM_BULLETS];
    logic [Y_W-1:0] oys [NUM_BULLETS];
    assign tick = cnt == '0 && state == IDLE;
    assign nidx = idx + 1'b1;
    assign last = idx == IW'(NUM_BULLETS - 1);
    assign plot.req = state == ERASE || state == DRAW;
    // lowest clear bit of active; zero when every slot is busy
    assign load = fire ? ~active & (active + 1'b1) : '0;
    for (genvar i = 0; i < NUM_BULLETS; i++) begin : g_slot
        bullet_slot #(.X_MAX(X_MAX), .Y_MAX(Y_MAX), .X_W(X_W), .Y_W(Y_W)) u_slot (
            .clk(clk),
            .resetn(resetn),
            .tick(tick),
            .load(load[i]),
            .collide(collide[i]),
            .start_x(start_x),
            .start_y(start_y),
            .dir(dir_t'(dir)),
            .active(active[i]),
            .x(xs[i]),
            .ox(oxs[i]),
            .y(ys[i]),
            .oy(oys[i]),
            .er(er[i]),
            .dr(dr[i])
        );
    end
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
            idx <= '0;
            cnt <= CW'(STEP_DIV - 1);
            fire_drop <= 1'b0;
            plot.x <= '0;
            plot.y <= '0;
            plot.erase <= 1'b0;
        end else begin
            state <= state_n;
            idx <= idx_n;
            cnt <= cnt != '0 ? cnt - 1'b1 : tick ? CW'(STEP_DIV - 1) : cnt;
            fire_drop <= fire && &active;
            plot.x <= px_n;
            plot.y <= py_n;
            plot.erase <= pe_n;
        end
    end
    // pixel is latched on entry to ERASE/DRAW so it cannot shift under a reload mid-beat
    always_comb begin
        state_n = state;
        idx_n = idx;
        px_n = plot.x;
        py_n = plot.y;
        pe_n = plot.erase;
        case (state)
            IDLE: if (tick) begin
                idx_n = '0;
                state_n = active[0] ? ERASE : NEXT;
                px_n = xs[0];
                py_n = ys[0];
                pe_n = 1'b1;
            end
            ERASE: if (plot.ack && dr[idx] && !collide[idx]) begin
                state_n = DRAW;
                px_n = xs[idx];
                py_n = ys[idx];
                pe_n = 1'b0;
            end else if (plot.ack) begin
                state_n = NEXT;
            end
            DRAW: if (plot.ack) state_n = NEXT;
            default: if (last) begin
                state_n = IDLE;
            end else begin
                idx_n = nidx;
                state_n = er[nidx] ? ERASE : NEXT;
                px_n = oxs[nidx];
                py_n = oys[nidx];
                pe_n = 1'b1;
            end
        endcase
    end
endmodule

// File: tb/tb_bullet_pool.sv
// tb_bullet_pool: directed and random stimulus checked against a queue-of-beats reference model
module tb_bullet_pool;
    localparam int NB = 4;
    localparam int SD = 10;
    localparam int XM = 159;
    localparam int YM = 119;
    typedef struct packed {
        int kind;
        int slot;
        int x;
        int y;
    } beat_t;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic fire = 1'b0;
    logic fire_drop;
    logic [7:0] start_x = '0;
    logic [6:0] start_y = '0;
    logic [2:0] dir = '0;
    logic [NB-1:0] collide = '0;
    logic [NB-1:0] active;
    int n_chk = 0;
    int n_pass = 0;
    beat_t q[$];
    int m_act [NB];
    int m_x [NB];
    int m_y [NB];
    int m_dir [NB];
    int m_cnt = SD - 1;
    int m_drop = 0;
    int dxt [8] = '{0, 1, 1, 1, 0, -1, -1, -1};
    int dyt [8] = '{-1, -1, 0, 1, 1, 1, 0, -1};
    bullet_pool_if #(.X_W(8), .Y_W(7)) plot_if ();
    bullet_pool #(.NUM_BULLETS(NB), .STEP_DIV(SD)) dut (
        .clk(clk),
        .resetn(resetn),
        .fire(fire),
        .start_x(start_x),
        .start_y(start_y),
        .dir(dir),
        .collide(collide),
        .active(active),
        .fire_drop(fire_drop),
        .plot(plot_if)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input int exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask
    function automatic beat_t mk(input int k, input int s, input int x, input int y);
        beat_t b;
        b.kind = k;
        b.slot = s;
        b.x = x;
        b.y = y;
        return b;
    endfunction
    // kind 0 = slot bookkeeping cycle, 1 = erase pixel, 2 = draw pixel
    task automatic model_edge();
        int pre [NB];
        int full;
        int ld;
        int nx;
        int ny;
        bit hit;
        bit tk;
        beat_t nq[$];
        if (!resetn) begin
            for (int i = 0; i < NB; i++) begin
                m_act[i] = 0;
                m_x[i] = 0;
                m_y[i] = 0;
            end
            q.delete();
            m_cnt = SD - 1;
            m_drop = 0;
            return;
        end
        full = 1;
        ld = -1;
        for (int i = 0; i < NB; i++) begin
            pre[i] = m_act[i];
            if (m_act[i] == 0) begin
                full = 0;
                if (ld < 0) ld = i;
            end
        end
        m_drop = (fire && full != 0) ? 1 : 0;
        tk = m_cnt == 0 && q.size() == 0;
        if (m_cnt != 0) m_cnt--;
        else if (tk) m_cnt = SD - 1;
        for (int k = 0; k < q.size(); k++)
            if (!(k > 0 && q[k].kind == 2 && collide[q[k].slot])) nq.push_back(q[k]);
        q = nq;
        if (q.size() > 0 && (q[0].kind == 0 || plot_if.ack)) q.delete(0);
        if (tk) begin
            for (int i = 0; i < NB; i++) begin
                if (pre[i] != 0) begin
                    nx = (m_x[i] + dxt[m_dir[i]]) & 255;
                    ny = (m_y[i] + dyt[m_dir[i]]) & 127;
                    hit = nx == 0 || nx == XM || ny == 0 || ny == YM;
                    q.push_back(mk(1, i, m_x[i], m_y[i]));
                    if (!hit && !collide[i]) q.push_back(mk(2, i, nx, ny));
                    if (hit) m_act[i] = 0;
                    m_x[i] = nx;
                    m_y[i] = ny;
                end
                q.push_back(mk(0, i, 0, 0));
            end
        end
        for (int i = 0; i < NB; i++) if (collide[i]) m_act[i] = 0;
        if (fire && ld >= 0) begin
            m_act[ld] = 1;
            m_x[ld] = start_x;
            m_y[ld] = start_y;
            m_dir[ld] = dir;
        end
    endtask
    task automatic check_outputs();
        logic [NB-1:0] ea;
        bit px;
        for (int i = 0; i < NB; i++) ea[i] = m_act[i] != 0;
        px = q.size() > 0 && q[0].kind != 0;
        check("active", active, ea);
        check("fire_drop", fire_drop, m_drop);
        check("plot_req", plot_if.req, px);
        if (px) begin
            check("plot_x", plot_if.x, q[0].x);
            check("plot_y", plot_if.y, q[0].y);
            check("plot_erase", plot_if.erase, q[0].kind == 1);
        end
    endtask
    task automatic step(input bit f, input int sx, input int sy, input int d, input int col, input bit ack, input bit rn);
        fire = f;
        start_x = 8'(sx);
        start_y = 7'(sy);
        dir = 3'(d);
        collide = col[NB-1:0];
        plot_if.ack = ack;
        resetn = rn;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
        if (!rn) begin
            check("rst_plot_x", plot_if.x, 0);
            check("rst_plot_y", plot_if.y, 0);
            check("rst_plot_erase", plot_if.erase, 0);
        end
    endtask
    task automatic idle(input int n, input bit ack);
        repeat (n) step(0, 0, 0, 0, 0, ack, 1);
    endtask
    initial begin
        bit ok;
        int col;
        repeat (3) step(1, 5, 5, 0, 15, 1, 0);
        step(1, 80, 60, 2, 0, 1, 1);
        idle(850, 1);
        check("east_edge_done", active, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) step(1, 20 + 10 * i, 30 + 5 * i, i, 0, 1, 1);
        check("fifth_drop", fire_drop, 1);
        check("fifth_full", active, 4'hf);
        idle(40, 0);
        idle(60, 1);
        step(0, 0, 0, 0, 0, 1, 0);
        step(1, 40, 40, 2, 0, 1, 1);
        step(1, 60, 60, 4, 0, 1, 1);
        step(1, 70, 30, 6, 0, 1, 1);
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (m_cnt == 0 && q.size() == 0) ok = 1;
            else idle(1, 1);
        end
        check("tick_wait", ok, 1);
        step(1, 50, 50, 1, 4'b0010, 1, 1);
        idle(12, 1);
        check("collide_slot1", active[1], 0);
        check("collide_fire_slot3", active[3], 1);
        step(0, 0, 0, 0, 0, 1, 0);
        step(1, 1, 1, 7, 0, 1, 1);
        idle(15, 1);
        check("corner_done", active, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        step(1, 30, 30, 3, 0, 1, 1);
        step(1, 90, 90, 5, 0, 1, 1);
        ok = 0;
        for (int i = 0; i < 30 && !ok; i++) begin
            if (q.size() > 0 && q[0].kind == 2) ok = 1;
            else idle(1, 1);
        end
        check("draw_wait", ok, 1);
        step(1, 9, 9, 1, 4'b0001, 0, 0);
        step(1, 40, 40, 2, 0, 1, 1);
        idle(20, 1);
        for (int c = 0; c < 3000; c++) begin
            col = 0;
            for (int i = 0; i < NB; i++) if ($urandom_range(0, 59) == 0) col |= 1 << i;
            step($urandom_range(0, 7) == 0, $urandom_range(1, XM - 1), $urandom_range(1, YM - 1),
                 $urandom_range(0, 7), col, $urandom_range(0, 9) < 7, $urandom_range(0, 999) != 0);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
